aes_inv_key_expander: RTL

- Reverse AES-128 key schedule for the decryption datapath.
- Accepts the final (round-10) round key and regenerates round keys 10, 9, … 0 in descending order, one valid/ready beat per key.
- Sits between key storage and the inverse-cipher round logic, so decryption can start from the last round key without holding all 11 keys.
- Byte-serial s-box substitution, matching the forward expander's area profile.

---
 rtl/aes_pkg.sv | 42 ++++
 rtl/aes_sbox_lut.sv | 35 +++
 rtl/aes_inv_key_expander.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
//   Constants and helpers shared by the AES key-schedule blocks.
//   Contents:
//     KEY_W / WORD_W / NR  : key width, word width, number of rounds
//     ST_*                 : expander state encoding (IDLE, EMIT, XOR, SUB, MIX)
//     rcon(round)          : round constant for rounds 1..10 (0 elsewhere)
//     rot_word(w)          : one-byte left rotation of a 32-bit word
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int KEY_W  = 128;
  localparam int WORD_W = 32;
  localparam int NR     = 10;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EMIT = 3'd1;
  localparam logic [2:0] ST_XOR  = 3'd2;
  localparam logic [2:0] ST_SUB  = 3'd3;
  localparam logic [2:0] ST_MIX  = 3'd4;

  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
    return {w[WORD_W-9:0], w[WORD_W-1:WORD_W-8]};
  endfunction

endpackage

// File: rtl/aes_sbox_lut.sv
// -----------------------------------------------------------------------------
// aes_sbox_lut
//   Combinational AES forward S-box, one byte in, one byte out. Shared with
//   the forward key expander.
//   Ports:
//     data  : input byte
//     subst : substituted byte
// -----------------------------------------------------------------------------
module aes_sbox_lut (
  input  logic [7:0] data,
  output logic [7:0] subst
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign subst = SBOX[data];

endmodule

// File: rtl/aes_inv_key_expander.sv
// -----------------------------------------------------------------------------
// aes_inv_key_expander
//   Reverse AES-128 key schedule. Takes the round-10 key and streams round
//   keys 10, 9, ... 0 over a valid/ready interface, regenerating each previous
//   key from the current one with a byte-serial S-box (SUB_BPC bytes/cycle).
//
//   Parameters:
//     NR      : number of rounds (only 10 is meaningful)
//     SUB_BPC : S-box bytes substituted per cycle (1, 2 or 4)
//
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     in_valid / in_ready : round-10 key handshake (ready only when idle)
//     in_key              : round-10 key, [127:96] = column 0
//     out_valid/out_ready : round-key handshake
//     out_key, out_round  : current round key and its round index
//     done                : one-cycle pulse after the round-0 handshake
//
//   Optional (`define INV_KEY_BANK_EN):
//     rd_index  : bank read index (values above 10 read as zero)
//     rd_key    : bank[rd_index], combinational
//     bank_full : set once round 0 has been written, cleared on a new accept
// -----------------------------------------------------------------------------
module aes_inv_key_expander
  import aes_pkg::*;
#(
  parameter int NR      = aes_pkg::NR,
  parameter int SUB_BPC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [KEY_W-1:0] out_key,
  output logic [3:0]       out_round,
  output logic             done
`ifdef INV_KEY_BANK_EN
  ,
  input  logic [3:0]       rd_index,
  output logic [KEY_W-1:0] rd_key,
  output logic             bank_full
`endif
);

  localparam int SUB_CYC = 4 / SUB_BPC;

  logic [2:0]        state;
  logic [KEY_W-1:0]  cur;
  logic [3:0]        r;
  logic [WORD_W-1:0] temp;
  logic [1:0]        sub_cnt;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_EMIT);
  assign out_key   = cur;
  assign out_round = r;

  // Byte lanes handled this SUB cycle, least-significant byte first.
  logic [1:0] byte_sel [SUB_BPC];
  logic [7:0] sbox_out [SUB_BPC];

  for (genvar g = 0; g < SUB_BPC; g++) begin : g_sbox
    assign byte_sel[g] = 2'(int'(sub_cnt) * SUB_BPC + g);
    aes_sbox_lut u_sbox (
      .data  (temp[8*byte_sel[g] +: 8]),
      .subst (sbox_out[g])
    );
  end

  // cur is reused as the working register: XOR rewrites columns 1..3 into the
  // previous key's columns 1..3 while column 0 is kept for the MIX step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cur     <= '0;
      r       <= '0;
      temp    <= '0;
      sub_cnt <= '0;
      done    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch
      // reads the pre-edge values, e.g. the XOR step mixes old columns.
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            cur   <= in_key;
            r     <= 4'(NR);
            state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (r == 4'd0) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              state <= ST_XOR;
            end
          end
        end
        ST_XOR: begin
          cur[95:64] <= cur[95:64] ^ cur[127:96];
          cur[63:32] <= cur[63:32] ^ cur[95:64];
          cur[31:0]  <= cur[31:0]  ^ cur[63:32];
          temp       <= rot_word(cur[31:0] ^ cur[63:32]);
          sub_cnt    <= '0;
          state      <= ST_SUB;
        end
        ST_SUB: begin
          for (int i = 0; i < SUB_BPC; i++) begin
            temp[8*byte_sel[i] +: 8] <= sbox_out[i];
          end
          if (sub_cnt == 2'(SUB_CYC - 1)) begin
            state <= ST_MIX;
          end else begin
            sub_cnt <= sub_cnt + 2'd1;
          end
        end
        ST_MIX: begin
          cur[127:96] <= cur[127:96] ^ temp ^ {rcon(r), 24'h0};
          r           <= r - 4'd1;
          state       <= ST_EMIT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef INV_KEY_BANK_EN
  logic [KEY_W-1:0] bank [0:10];

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the bank is cleared on reset so stale keys from an abandoned
      // sequence can never be read back; this forces flops rather than RAM.
      for (int i = 0; i <= 10; i++) begin
        bank[i] <= '0;
      end
      bank_full <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        bank_full <= 1'b0;
      end
      if (out_valid && out_ready) begin
        bank[r] <= cur;
        if (r == 4'd0) begin
          bank_full <= 1'b1;
        end
      end
    end
  end

  assign rd_key = (rd_index <= 4'd10) ? bank[rd_index] : '0;
`endif

endmodule
